// File: rtl/fft_pkg.sv
// fft_pkg: state type, bit-reversal, twiddle ROM generators and fixed-point helpers for fft_iter_core.
package fft_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam real PI = 3.14159265358979323846;

    function automatic int bitrev(input int v, input int bits);
        int r = 0;
        for (int b = 0; b < bits; b++) r = (r << 1) | ((v >> b) & 1);
        return r;
    endfunction

    function automatic int rnd(input real x);
        return x >= 0.0 ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    // +1.0 maps to 2^(w-1)-1 so the table never needs a wider word
    function automatic int tw_cos(input int idx, input int n, input int w);
        return rnd($cos(2.0 * PI * idx / n) * ((2.0 ** (w - 1)) - 1.0));
    endfunction

    function automatic int tw_sin(input int idx, input int n, input int w);
        return rnd($sin(2.0 * PI * idx / n) * ((2.0 ** (w - 1)) - 1.0));
    endfunction

    function automatic longint round_shift(input longint v, input int sh);
        return (v + (longint'(1) << (sh - 1))) >>> sh;
    endfunction

    function automatic longint saturate(input longint v, input int w);
        longint hi = (longint'(1) << (w - 1)) - 1;
        longint lo = -hi - 1;
        return v > hi ? hi : v < lo ? lo : v;
    endfunction

endpackage

// File: rtl/fft_iter_core_butterfly.sv
// fft_butterfly: combinational radix-2 DIT butterfly with rounding, saturation and overflow flag.
// FFT_BLOCK_SCALE_EN halves both outputs (round half-up) before saturation.
module fft_butterfly
    import fft_pkg::*;
#(
    parameter int D_W  = 16,
    parameter int TW_W = 16
) (
    input  logic signed [D_W-1:0]  i_ar,
    input  logic signed [D_W-1:0]  i_ai,
    input  logic signed [D_W-1:0]  i_br,
    input  logic signed [D_W-1:0]  i_bi,
    input  logic signed [TW_W-1:0] i_wr,
    input  logic signed [TW_W-1:0] i_wi,
    output logic signed [D_W-1:0]  o_xr,
    output logic signed [D_W-1:0]  o_xi,
    output logic signed [D_W-1:0]  o_yr,
    output logic signed [D_W-1:0]  o_yi,
    output logic                   o_ovf
);
    longint w_tr, w_ti;
    longint w_s [4];
    longint w_c [4];

    always_comb begin
        w_tr = round_shift(longint'(i_br) * longint'(i_wr) - longint'(i_bi) * longint'(i_wi), TW_W - 1);
        w_ti = round_shift(longint'(i_br) * longint'(i_wi) + longint'(i_bi) * longint'(i_wr), TW_W - 1);
        w_s[0] = longint'(i_ar) + w_tr;
        w_s[1] = longint'(i_ai) + w_ti;
        w_s[2] = longint'(i_ar) - w_tr;
        w_s[3] = longint'(i_ai) - w_ti;
`ifdef FFT_BLOCK_SCALE_EN
        for (int n = 0; n < 4; n++) w_s[n] = round_shift(w_s[n], 1);
`endif
        o_ovf = 1'b0;
        for (int n = 0; n < 4; n++) begin
            w_c[n] = saturate(w_s[n], D_W);
            o_ovf = o_ovf | (w_c[n] != w_s[n]);
        end
        o_xr = D_W'(w_c[0]);
        o_xi = D_W'(w_c[1]);
        o_yr = D_W'(w_c[2]);
        o_yi = D_W'(w_c[3]);
    end

endmodule

// File: rtl/fft_iter_core.sv
// fft_iter_core: iterative in-place radix-2 DIT FFT/IFFT, one butterfly per cycle, valid/ready framing.
// Optional FFT_BLOCK_SCALE_EN gives 1/N total gain via per-stage halving in fft_butterfly.
module fft_iter_core
    import fft_pkg::*;
#(
    parameter int N_POINTS = 64,
    parameter int LOG2N    = 6,
    parameter int D_W      = 16,
    parameter int TW_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_inverse,
    input  logic [N_POINTS*D_W-1:0] in_re_sig,
    input  logic [N_POINTS*D_W-1:0] in_im_sig,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N_POINTS*D_W-1:0] out_re_sig,
    output logic [N_POINTS*D_W-1:0] out_im_sig,
    output logic                    ovf
);
    localparam int HALF = N_POINTS / 2;

    if ((1 << LOG2N) != N_POINTS || N_POINTS < 4 || N_POINTS > 256) begin : g_bad_cfg
        $error("fft_iter_core: N_POINTS must equal 2**LOG2N and lie in 4..256");
    end

    state_t                 r_state;
    logic signed [D_W-1:0]  r_re [N_POINTS];
    logic signed [D_W-1:0]  r_im [N_POINTS];
    logic [3:0]             r_stage;
    logic [LOG2N-2:0]       r_k;
    logic                   r_inv;

    logic [LOG2N-1:0]       w_k, w_half, w_pos, w_i0, w_i1;
    logic [LOG2N-2:0]       w_tw;
    logic signed [TW_W-1:0] w_cos [HALF];
    logic signed [TW_W-1:0] w_sin [HALF];
    logic signed [TW_W-1:0] w_wr, w_wi;
    logic signed [D_W-1:0]  w_xr, w_xi, w_yr, w_yi;
    logic                   w_ovf;

    for (genvar j = 0; j < HALF; j++) begin : g_rom
        assign w_cos[j] = TW_W'(tw_cos(j, N_POINTS, TW_W));
        assign w_sin[j] = TW_W'(tw_sin(j, N_POINTS, TW_W));
    end

    always_comb begin
        w_k    = {1'b0, r_k};
        w_half = LOG2N'(1) << r_stage;
        w_pos  = w_k & (w_half - 1'b1);
        w_i0   = ((w_k >> r_stage) << (r_stage + 4'd1)) + w_pos;
        w_i1   = w_i0 | w_half;
        w_tw   = (LOG2N-1)'(w_pos << (LOG2N - 1 - r_stage));
        w_wr   = w_cos[w_tw];
        w_wi   = r_inv ? w_sin[w_tw] : -w_sin[w_tw];
    end

    fft_butterfly #(.D_W(D_W), .TW_W(TW_W)) u_bfly (
        .i_ar (r_re[w_i0]),
        .i_ai (r_im[w_i0]),
        .i_br (r_re[w_i1]),
        .i_bi (r_im[w_i1]),
        .i_wr (w_wr),
        .i_wi (w_wi),
        .o_xr (w_xr),
        .o_xi (w_xi),
        .o_yr (w_yr),
        .o_yi (w_yi),
        .o_ovf(w_ovf)
    );

    for (genvar j = 0; j < N_POINTS; j++) begin : g_out
        assign out_re_sig[D_W*j +: D_W] = r_re[j];
        assign out_im_sig[D_W*j +: D_W] = r_im[j];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            r_inv     <= 1'b0;
            r_stage   <= '0;
            r_k       <= '0;
            for (int i = 0; i < N_POINTS; i++) begin
                r_re[i] <= '0;
                r_im[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    // bit-reversed load so the DIT passes produce natural-order bins
                    for (int i = 0; i < N_POINTS; i++) begin
                        r_re[i] <= in_re_sig[D_W*bitrev(i, LOG2N) +: D_W];
                        r_im[i] <= in_im_sig[D_W*bitrev(i, LOG2N) +: D_W];
                    end
                    r_inv    <= in_inverse;
                    ovf      <= 1'b0;
                    r_stage  <= '0;
                    r_k      <= '0;
                    in_ready <= 1'b0;
                    r_state  <= RUN;
                end
                RUN: begin
                    r_re[w_i0] <= w_xr;
                    r_im[w_i0] <= w_xi;
                    r_re[w_i1] <= w_yr;
                    r_im[w_i1] <= w_yi;
                    ovf        <= ovf | w_ovf;
                    r_k        <= r_k + 1'b1;
                    if (r_k == (LOG2N-1)'(HALF - 1)) begin
                        r_stage <= r_stage + 4'd1;
                        if (r_stage == 4'(LOG2N - 1)) begin
                            r_state   <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: if (out_ready) begin
                    r_state   <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_iter_core.sv
// tb_fft_iter_core: table-driven frames checked against a direct DFT model through a scoreboard queue.
module tb_fft_iter_core;
    localparam int N = 64, LOG2N = 6, D_W = 16, TW_W = 16, LAT = LOG2N * N / 2, NREC = 7;
    localparam real PI = 3.14159265358979323846;
`ifdef FFT_BLOCK_SCALE_EN
    localparam bit SCALE = 1'b1;
`else
    localparam bit SCALE = 1'b0;
`endif

    // kind: 0 impulse, 1 dc, 2 tone bin 4, 3 all-1000, 4 random
    typedef struct {
        int kind;
        bit inv;
        int tol;
        bit ovf_raw;
        bit all_raw;
    } vec_t;

    vec_t vecs [NREC];
    int   in_re [NREC][N];
    int   in_im [NREC][N];
    int   ex_re [NREC][N];
    int   ex_im [NREC][N];
    bit   ex_ovf [NREC];
    bit   chk_all [NREC];
    int   sb_q [$];
    int   n_checks = 0;
    int   n_pass = 0;

    logic clk = 0, rst = 0, in_valid = 0, in_inverse = 0, out_ready = 0;
    logic in_ready, out_valid, ovf;
    logic [N*D_W-1:0] in_re_sig = '0, in_im_sig = '0, out_re_sig, out_im_sig;

    fft_iter_core #(.N_POINTS(N), .LOG2N(LOG2N), .D_W(D_W), .TW_W(TW_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_inverse(in_inverse),
        .in_re_sig(in_re_sig), .in_im_sig(in_im_sig),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re_sig(out_re_sig), .out_im_sig(out_im_sig),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int rnd(input real x);
        return x >= 0.0 ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    function automatic int clip(input int v);
        return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
    endfunction

    function automatic int iabs(input int v);
        return v < 0 ? -v : v;
    endfunction

    task automatic chk(input bit ok, input string name, input int act, input int req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, req);
    endtask

    task automatic build();
        real sr, si, ang;
        vecs[0] = '{0, 1'b0, 2, 1'b0, 1'b1};
        vecs[1] = '{1, 1'b0, 2, 1'b0, 1'b1};
        vecs[2] = '{2, 1'b0, 12, 1'b1, 1'b0};
        vecs[3] = '{3, 1'b1, 12, 1'b1, 1'b1};
        vecs[4] = '{4, 1'b0, 12, 1'b0, 1'b1};
        vecs[5] = '{4, 1'b1, 12, 1'b0, 1'b1};
        vecs[6] = '{4, 1'b0, 12, 1'b0, 1'b1};
        for (int r = 0; r < NREC; r++) begin
            for (int n = 0; n < N; n++) begin
                in_im[r][n] = 0;
                case (vecs[r].kind)
                    0: in_re[r][n] = n == 0 ? 1000 : 0;
                    1: in_re[r][n] = 100;
                    2: in_re[r][n] = rnd(8000.0 * $cos(2.0 * PI * 4.0 * n / N));
                    3: in_re[r][n] = 1000;
                    default: begin
                        in_re[r][n] = int'($urandom_range(600)) - 300;
                        in_im[r][n] = int'($urandom_range(600)) - 300;
                    end
                endcase
            end
            for (int k = 0; k < N; k++) begin
                sr = 0.0;
                si = 0.0;
                for (int n = 0; n < N; n++) begin
                    ang = (vecs[r].inv ? 2.0 : -2.0) * PI * ((n * k) % N) / N;
                    sr += in_re[r][n] * $cos(ang) - in_im[r][n] * $sin(ang);
                    si += in_re[r][n] * $sin(ang) + in_im[r][n] * $cos(ang);
                end
                if (SCALE) begin
                    sr = sr / N;
                    si = si / N;
                end
                ex_re[r][k] = clip(rnd(sr));
                ex_im[r][k] = clip(rnd(si));
            end
            ex_ovf[r]  = vecs[r].ovf_raw && !SCALE;
            chk_all[r] = vecs[r].all_raw || SCALE;
        end
    endtask

    task automatic load(input int r);
        for (int i = 0; i < N; i++) begin
            in_re_sig[D_W*i +: D_W] = D_W'(in_re[r][i]);
            in_im_sig[D_W*i +: D_W] = D_W'(in_im[r][i]);
        end
        in_inverse = vecs[r].inv;
    endtask

    task automatic send(input int r, input string tag);
        int w = 0;
        @(negedge clk);
        load(r);
        in_valid = 1'b1;
        while (!in_ready && w < 1000) begin
            @(negedge clk);
            w++;
        end
        chk(w < 1000, {tag, "_accept_wait"}, w, 0);
        @(posedge clk);
        sb_q.push_back(r);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int c = 0;
        do begin
            @(posedge clk);
            #1 c++;
        end while (!out_valid && c < 2 * LAT);
        chk(c == LAT, {tag, "_latency"}, c, LAT);
        chk(!in_ready, {tag, "_in_ready_busy"}, in_ready, 0);
    endtask

    task automatic compare(input string tag);
        int r, gr, gi, bad, bk, bg, bw;
        bad = 0; bk = 0; bg = 0; bw = 0;
        if (sb_q.size() == 0) begin
            chk(1'b0, {tag, "_scoreboard_empty"}, 0, 1);
            return;
        end
        r = sb_q.pop_front();
        for (int k = 0; k < N; k++) begin
            gr = int'($signed(out_re_sig[D_W*k +: D_W]));
            gi = int'($signed(out_im_sig[D_W*k +: D_W]));
            if ((chk_all[r] || iabs(ex_re[r][k]) >= 32767) && iabs(gr - ex_re[r][k]) > vecs[r].tol) begin
                if (bad == 0) begin bk = k; bg = gr; bw = ex_re[r][k]; end
                bad++;
            end
            if (chk_all[r] && iabs(gi - ex_im[r][k]) > vecs[r].tol) begin
                if (bad == 0) begin bk = k + 1000; bg = gi; bw = ex_im[r][k]; end
                bad++;
            end
        end
        chk(bad == 0, $sformatf("%s_bins(first bad %0d, im if >=1000, %0d bad)", tag, bk, bad), bg, bw);
        chk(ovf == ex_ovf[r], {tag, "_ovf"}, ovf, ex_ovf[r]);
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk(!out_valid, {tag, "_out_valid_drop"}, out_valid, 0);
    endtask

    task automatic run_frame(input int r, input string tag);
        send(r, tag);
        wait_done(tag);
        compare(tag);
        release_out(tag);
    endtask

    initial begin
        logic [N*D_W-1:0] snap;
        bit stable;
        int busy;
        build();
        repeat (3) @(posedge clk);
        #1;
        chk(in_ready, "rst_in_ready", in_ready, 1);
        chk(!out_valid, "rst_out_valid", out_valid, 0);
        chk(!ovf, "rst_ovf", ovf, 0);
        chk(out_re_sig == '0 && out_im_sig == '0, "rst_outputs_zero", int'(out_re_sig != '0), 0);
        @(negedge clk) rst = 1'b1;

        run_frame(0, "impulse");
        run_frame(1, "dc");
        run_frame(2, "tone");
        run_frame(3, "inverse");

        send(4, "bp");
        wait_done("bp");
        @(negedge clk);
        load(5);
        in_valid = 1'b1;
        snap = out_re_sig ^ out_im_sig;
        stable = 1'b1;
        busy = 0;
        repeat (50) begin
            @(negedge clk);
            stable &= out_valid && ((out_re_sig ^ out_im_sig) == snap);
            busy += int'(in_ready);
        end
        chk(stable, "bp_outputs_stable", int'(stable), 1);
        chk(busy == 0, "bp_in_ready_low", busy, 0);
        compare("bp");
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk(in_ready && !out_valid, "bp_handshake_idle", int'(in_ready), 1);
        @(posedge clk);
        sb_q.push_back(5);
        #1 chk(!in_ready, "bp_held_frame_accepted", in_ready, 0);
        in_valid = 1'b0;
        wait_done("bp_next");
        compare("bp_next");
        release_out("bp_next");

        send(6, "mid_rst");
        repeat (100) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk(!out_valid, "mid_rst_out_valid", out_valid, 0);
        chk(in_ready, "mid_rst_in_ready", in_ready, 1);
        chk(!ovf, "mid_rst_ovf", ovf, 0);
        chk(out_re_sig == '0 && out_im_sig == '0, "mid_rst_outputs_zero", int'(out_re_sig != '0), 0);
        void'(sb_q.pop_back());
        @(negedge clk) rst = 1'b1;
        run_frame(6, "after_rst");

        chk(sb_q.size() == 0, "scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
